// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if -- EX-stage bus between the pipeline and the HI/LO multiply/divide unit.
//
// Handshake: start/mdu_op/a/b describe a command that is valid in the current cycle.
// The unit takes it at the next rising edge only when it is idle and flush is low.
// stall is the inverse of ready. It is raised combinationally in the cycle a divide
// is presented, and stays high for the whole divide. While stall is high the
// pipeline holds the instruction in EX, and the unit ignores start and mdu_op.
// done pulses for one cycle after a divide has written HI/LO.
//
// Signals:
//   flush        pipeline -> mdu  cancel any in-flight divide
//   start        pipeline -> mdu  command valid
//   mdu_op[2:0]  pipeline -> mdu  operation code
//   a, b         pipeline -> mdu  rs / rt operands
//   hi, lo       mdu -> pipeline  HI / LO registers
//   stall        mdu -> pipeline  hold IF/ID/EX
//   done         mdu -> pipeline  divide-complete pulse
//   dbg_busy     mdu -> observer  FSM is in the DIV state
//   div_by_zero  mdu -> pipeline  divide-by-zero pulse (MDU_DIVZERO_FLAG_EN only)
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             start;
  logic [2:0]       mdu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             stall;
  logic             done;
  logic             dbg_busy;
`ifdef MDU_DIVZERO_FLAG_EN
  logic             div_by_zero;
`endif

  modport master (
    output flush, start, mdu_op, a, b,
`ifdef MDU_DIVZERO_FLAG_EN
    input  div_by_zero,
`endif
    input  hi, lo, stall, done, dbg_busy
  );

  modport slave (
    input  flush, start, mdu_op, a, b,
`ifdef MDU_DIVZERO_FLAG_EN
    output div_by_zero,
`endif
    output hi, lo, stall, done, dbg_busy
  );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo -- multiply/divide unit with HI/LO registers for the EX stage.
//
// Operations (mdu_op):
//   000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 no-op.
// MULT, MULTU, MTHI and MTLO complete at the accepting edge.
// DIV and DIVU run a WIDTH-iteration restoring divider and stall the pipeline for
// WIDTH+1 cycles.
//
// Ports:
//   clk   core clock
//   rst   asynchronous active-low reset
//   bus   mdu_hilo_if.slave (flush/start/mdu_op/a/b in; hi/lo/stall/done/dbg_busy out)
//
// Optional build macro: MDU_DIVZERO_FLAG_EN.
//   Adds bus.div_by_zero. A divide by zero then finishes in one cycle with hi=a and
//   lo=all ones. Without the macro, a divide by zero runs the full iteration: the
//   divider naturally produces hi=a and an all-ones quotient before the sign fix.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mdu_hilo_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;    // partial remainder, always < divisor
  logic [WIDTH-1:0] quo_q;    // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;    // divisor magnitude
  logic             qneg_q;   // negate quotient at the end
  logic             rneg_q;   // negate remainder at the end
  logic             done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
  logic             dbz_q;
  logic             b_zero;
`endif

  logic             accept;
  logic             is_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic             last;
  logic [2*WIDTH-1:0] prod_s, prod_u;

  assign accept = (state_q == IDLE) && bus.start && !bus.flush;
  assign is_div = (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_DIVU);

  // Only signed DIV folds the operand signs; DIVU uses the raw values.
  assign a_neg = (bus.mdu_op == OP_DIV) && bus.a[WIDTH-1];
  assign b_neg = (bus.mdu_op == OP_DIV) && bus.b[WIDTH-1];
  assign a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;

  // Sign extension to 2*WIDTH makes the low 2*WIDTH bits of the unsigned product
  // equal to the signed product.
  assign prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // One restoring step. The shifted remainder needs WIDTH+1 bits, because
  // 2*rem + 1 can exceed WIDTH bits when the divisor is large.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign take   = !diff[WIDTH];
  assign rem_nx = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], take};
  assign last   = (cnt_q == CW'(WIDTH - 1));

`ifdef MDU_DIVZERO_FLAG_EN
  assign b_zero = (bus.b == '0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef MDU_DIVZERO_FLAG_EN
        if (accept && is_div && !b_zero) state_d = DIV;
`else
        if (accept && is_div) state_d = DIV;
`endif
      end
      DIV: begin
        if (bus.flush || last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      dbz_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      dbz_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (bus.mdu_op)
              OP_MULT:  {hi_q, lo_q} <= prod_s;
              OP_MULTU: {hi_q, lo_q} <= prod_u;
              OP_MTHI:  hi_q <= bus.a;
              OP_MTLO:  lo_q <= bus.a;
              OP_DIV, OP_DIVU: begin
`ifdef MDU_DIVZERO_FLAG_EN
                if (b_zero) begin
                  hi_q   <= bus.a;
                  lo_q   <= '1;
                  done_q <= 1'b1;
                  dbz_q  <= 1'b1;
                end else begin
`endif
                  quo_q  <= a_mag;
                  dvs_q  <= b_mag;
                  rem_q  <= '0;
                  cnt_q  <= '0;
                  qneg_q <= a_neg ^ b_neg;
                  rneg_q <= a_neg;
`ifdef MDU_DIVZERO_FLAG_EN
                end
`endif
              end
              default: ;
            endcase
          end
        end
        DIV: begin
          if (!bus.flush) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              lo_q   <= qneg_q ? (~quo_nx + 1'b1) : quo_nx;
              hi_q   <= rneg_q ? (~rem_nx + 1'b1) : rem_nx;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The DIV term of stall is not gated by flush: the flushed cycle is still stalled,
  // and the state register drops it from the next cycle on.
  always_comb begin
    bus.stall = 1'b0;
    if (rst) begin
      bus.stall = ((state_q == IDLE) && bus.start && is_div && !bus.flush) ||
                  (state_q == DIV);
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = done_q;
  assign bus.dbg_busy = (state_q == DIV);
`ifdef MDU_DIVZERO_FLAG_EN
  assign bus.div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [63:0] exp_q[$];

  mdu_hilo_if #(.WIDTH(W)) bus ();

  mdu_hilo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

`ifdef MDU_DIVZERO_FLAG_EN
  localparam int DZ_STALL = 1;
  localparam logic [31:0] DZ_NEG_LO = 32'hFFFFFFFF;
`else
  localparam int DZ_STALL = 33;
  localparam logic [31:0] DZ_NEG_LO = 32'h00000001;
`endif

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called just after a negedge: presents the divide in that cycle (T).
  task automatic run_div(input string nm, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_stall, input bit noise);
    int  cnt;
    int  early_done;
    bit  ended;
    bus.flush = 1'b0; bus.start = 1'b1; bus.mdu_op = op; bus.a = a; bus.b = b;
    #1;
    chk({nm, " stall at T"}, 64'(bus.stall), 64'd1);
    cnt = 1; early_done = 0; ended = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (noise) begin
        bus.start = 1'b1; bus.mdu_op = 3'b110; bus.a = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (!bus.stall) begin
        ended = 1'b1;
        break;
      end
      cnt++;
      if (bus.done) early_done++;
    end
    bus.start = 1'b0;
    chk({nm, " completed"}, 64'(ended), 64'd1);
    chk({nm, " stall cycles"}, 64'(cnt), 64'(exp_stall));
    chk({nm, " done during stall"}, 64'(early_done), 64'd0);
    chk({nm, " done pulse"}, 64'(bus.done), 64'd1);
`ifdef MDU_DIVZERO_FLAG_EN
    chk({nm, " div_by_zero"}, 64'(bus.div_by_zero), 64'(b == 0));
`endif
    chk({nm, " hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({nm, " lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    #1;
    chk({nm, " done cleared"}, 64'(bus.done), 64'd0);
    chk({nm, " lo held"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int done_seen;
    logic [63:0] e;
    total = 0; bad = 0;
    rst = 1'b0;
    bus.flush = 1'b0; bus.start = 1'b0; bus.mdu_op = 3'b000; bus.a = '0; bus.b = '0;

    vecs[0] = '{"mult neg",     3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{"multu",        3'b010, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{"mthi",         3'b101, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFA};
    vecs[3] = '{"mtlo",         3'b110, 32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE};
    vecs[4] = '{"mult minmin",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5] = '{"multu maxmax", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[6] = '{"mult m1m1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[7] = '{"op none",      3'b000, 32'h55555555, 32'h3,        32'h00000000, 32'h00000001};
    vecs[8] = '{"op reserved",  3'b111, 32'h55555555, 32'h3,        32'h00000000, 32'h00000001};
    vecs[9] = '{"mult 7x-3",    3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};

    // reset state
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'b011; bus.b = 32'd1;
    #1;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    chk("reset busy", 64'(bus.dbg_busy), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;

    // single-cycle table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = vecs[i].op; bus.a = vecs[i].a; bus.b = vecs[i].b;
      #1;
      chk({vecs[i].name, " stall"}, 64'(bus.stall), 64'd0);
      exp_q.push_back({vecs[i].hi, vecs[i].lo});
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      e = exp_q.pop_front();
      chk({vecs[i].name, " hi"}, 64'(bus.hi), 64'(e[63:32]));
      chk({vecs[i].name, " lo"}, 64'(bus.lo), 64'(e[31:0]));
    end

    // divides
    @(negedge clk);
    run_div("div -7/2", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    @(negedge clk);
    run_div("divu 100/7 noise", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
    @(negedge clk);
    run_div("div min/-1", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1'b0);
    @(negedge clk);
    run_div("div neg/0", 3'b011, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, DZ_NEG_LO, DZ_STALL, 1'b0);

    // flush at T+10
    do_op(3'b101, 32'h11111111, 32'h0);
    do_op(3'b110, 32'h22222222, 32'h0);
    bus.start = 1'b1; bus.mdu_op = 3'b011; bus.a = 32'd100; bus.b = 32'd3;
    done_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 10) bus.flush = 1'b1;
      #1;
      if (bus.done) done_seen++;
    end
    chk("flush cycle stall", 64'(bus.stall), 64'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("after flush stall", 64'(bus.stall), 64'd0);
    chk("after flush done", 64'(bus.done + done_seen), 64'd0);
    chk("after flush hi", 64'(bus.hi), 64'h11111111);
    chk("after flush lo", 64'(bus.lo), 64'h22222222);
    run_div("divu 9/4", 3'b100, 32'd9, 32'd4, 32'd1, 32'd2, 33, 1'b0);

    // flush beats start in IDLE
    @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b1; bus.mdu_op = 3'b011; bus.a = 32'd50; bus.b = 32'd5;
    #1;
    chk("flush+div stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.mdu_op = 3'b001;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    #1;
    chk("flush+start busy", 64'(bus.dbg_busy), 64'd0);
    chk("flush+start hi", 64'(bus.hi), 64'd1);
    chk("flush+start lo", 64'(bus.lo), 64'd2);

    // reset mid-divide at T+5
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'b100; bus.a = 32'd1000; bus.b = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("mid rst hi", 64'(bus.hi), 64'd0);
    chk("mid rst lo", 64'(bus.lo), 64'd0);
    chk("mid rst stall", 64'(bus.stall), 64'd0);
    chk("mid rst busy", 64'(bus.dbg_busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post rst busy", 64'(bus.dbg_busy), 64'd0);
    run_div("divu 5/0", 3'b100, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DZ_STALL, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers for the 5-stage MIPS core; sits in EX.
- Executes instructions for which the main decoder raises the HI/LO write and ALU-select controls (MULT, MULTU, DIV, DIVU) and the HI/LO moves MTHI/MTLO.
- Supplies HI/LO to the MFHI/MFLO read path.
- Multiply and moves are single-cycle. Divide is a 32-iteration restoring divider that stalls the pipeline until its result is written.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous cancel of any in-flight divide (exception/branch flush)
- start  in  1  op valid this cycle (the EX instruction is an MDU op)
- mdu_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (no-op)
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- stall  out  1  hold IF/ID/EX; combinational
- done  out  1  one-cycle pulse after a divide writes HI/LO

Behaviour:
- Reset (rst=0, asynchronous):
  - hi=0, lo=0, state=IDLE, counter=0, done=0.
  - stall=0 while reset is asserted.
- States: IDLE, DIV.
- Commands are accepted only in IDLE with start=1. In DIV, start and mdu_op are ignored; stall keeps the pipeline from issuing new commands.
- MULT (signed 32x32) and MULTU (unsigned 32x32):
  - Full 64-bit product; {hi,lo} is written at the accepting edge.
  - Result is visible the next cycle. stall stays 0.
- MTHI: hi<=a at the accepting edge. MTLO: lo<=a. stall stays 0.
- DIV/DIVU acceptance, cycle T:
  - stall=1 combinationally in T.
  - At the end of T: latch |a| and |b| (raw values for DIVU), the quotient sign sa^sb and the remainder sign sa; counter=0; go to DIV.
- DIV state, cycles T+1..T+32:
  - One shift/subtract iteration per cycle; stall=1; counter increments.
  - At the edge ending T+32 (counter=WIDTH-1):
    - lo = quotient, negated if the quotient sign is set (DIV only).
    - hi = remainder, negated if sa is set (DIV only).
    - state goes to IDLE.
  - done=1 during T+33. stall=0 in T+33, so the divide instruction advances.
- Total divide stall: 33 cycles.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- flush=1 in any cycle:
  - state<=IDLE; the partial result is discarded; hi/lo are unchanged; no done pulse.
  - The stall term from state is 0 the next cycle.
  - flush takes priority over start in the same cycle, so nothing is accepted.
- Divide by zero (feature off): the iteration runs normally for 33 cycles.
  - hi=a.
  - lo=0xFFFFFFFF if the quotient sign is 0, otherwise 0x00000001.
  - Deterministic; no flag.
- Reset mid-divide: immediate return to the reset state; hi and lo are cleared.
- stall = (state==IDLE & start & mdu_op∈{DIV,DIVU} & !flush) | (state==DIV).

Optional Feature:
- MDU_DIVZERO_FLAG_EN.
- Defined:
  - Adds output div_by_zero (1 bit).
  - DIV/DIVU with b=0 skips the iteration: stall is 1 only in cycle T.
  - At the end of T: hi=a, lo=0xFFFFFFFF.
  - done=1 and div_by_zero=1 in T+1; div_by_zero is reset to 0.
- Undefined: no port is added, and divide by zero behaves as stated in Behaviour.

Test Plan:
- MULT a=0xFFFFFFFE, b=0x00000003 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall never 1.
- MULTU a=0xFFFFFFFE, b=0x00000003 -> hi=0x00000002, lo=0xFFFFFFFA; then MTHI a=0x12345678 -> hi=0x12345678, lo unchanged.
- DIV a=0xFFFFFFF9 (-7), b=2 accepted at T -> stall=1 for T..T+32; done=1 at T+33; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 -> after 33 stall cycles lo=14, hi=2; a start with MTLO during stall is ignored and lo stays 14.
- DIV started, flush at T+10 -> stall=0 from T+11; hi/lo hold their pre-divide values; no done; DIVU 9/4 issued at T+11 yields lo=2, hi=1.
- rst driven low at T+5 of a DIVU -> hi=0, lo=0, stall=0 immediately; after release, DIVU 5/0 -> hi=5, lo=0xFFFFFFFF (2-cycle completion with div_by_zero=1 when MDU_DIVZERO_FLAG_EN is defined).
